decode_nbits_pipe: RTL and testbench
====================================

DECODE_NBITS_PIPE -- requirements
Module: decode_nbits_pipe

Interface
REQ-001 SHALL have parameter N, default 3, meaning input code width; legal range 1..6.
REQ-002 SHALL have parameter MODE, default 0, meaning decode style: 0 = one-hot, 1 = thermometer.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream code valid.
REQ-006 in_ready  output  1  block can accept a code this cycle.
REQ-007 in_code  input  N  binary code to decode.
REQ-008 in_en  input  1  decode enable, sampled with in_code; 0 forces an all-zero result.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  downstream accepts head entry.
REQ-011 out_dec  output  2**N  decoded word of head entry.
REQ-012 out_code  output  N  in_code echoed from head entry.
REQ-013 level  output  2  buffer occupancy, 0..2.

Function
REQ-014 Decode SHALL be computed at accept time and stored with in_code; decode logic SHALL NOT sit between storage and outputs.
REQ-015 MODE=0: out_dec[i] = 1 iff i == code; exactly one bit set.
REQ-016 MODE=1: out_dec[i] = 1 iff i <= code; code 0 gives bit 0 only; code 2**N-1 gives all ones.
REQ-017 in_en=0 at accept SHALL store out_dec = all zeros and the real in_code; the handshake completes normally.
REQ-018 Storage SHALL be a 2-entry FIFO.
REQ-019 level SHALL equal the current entry count.
REQ-020 in_ready SHALL be 1 iff level < 2; it is a function of registered level only and has no combinational path from out_ready.
REQ-021 Push SHALL occur iff in_valid & in_ready at the clock edge.
REQ-022 Pop SHALL occur iff out_valid & out_ready at the clock edge.
REQ-023 out_valid SHALL be 1 iff level != 0.
REQ-024 Latency SHALL be 1 cycle: a code pushed at edge t is visible on out_* after edge t, with no same-cycle bypass when level = 0.
REQ-025 Push and pop in the same cycle at level = 1: level stays 1 and the new entry becomes head.
REQ-026 Push and pop in the same cycle at level = 0: not possible, because out_valid = 0.
REQ-027 Level = 2: push blocked and in_valid ignored; a pop drops level to 1 and in_ready returns the next cycle.
REQ-028 Pop at level 0 (out_ready=1, out_valid=0) SHALL have no effect.
REQ-029 When out_valid = 0, out_dec and out_code SHALL be driven to zero.
REQ-030 Sustained throughput SHALL be 1 code per cycle while out_ready = 1.
REQ-031 FIFO read/write pointers SHALL wrap modulo 2.
REQ-032 Order SHALL be strict FIFO; no entry is lost or duplicated.
REQ-033 Head entry and out_* SHALL remain stable while out_valid = 1 and out_ready = 0.

Reset
REQ-034 On rst_n = 0, the block SHALL asynchronously clear: level = 0, out_valid = 0, out_dec = 0, out_code = 0, pointers = 0.
REQ-035 While rst_n = 0, in_ready SHALL be 1, and in_valid SHALL be ignored (no push).
REQ-036 Reset asserted mid-operation SHALL discard all stored entries immediately.
REQ-037 Normal operation SHALL resume on the first rising clk edge after rst_n deasserts.

Verification (N=3)
REQ-038 MODE=0, in_en=1, codes 0..7 back-to-back with out_ready=1 -> out_dec = 0x01,0x02,...,0x80 one per cycle, each 1 cycle after push, level stays 1.
REQ-039 MODE=1, codes 0, 3, 7 -> out_dec = 0x01, 0x0F, 0xFF.
REQ-040 out_ready=0, push codes 5, 6, 2 -> level=2, in_ready=0, code 2 not accepted; then out_ready=1 -> out_dec = 0x20, then 0x40; code 2 accepted only after in_ready rises.
REQ-041 Level=1 with simultaneous push of code 4 and pop -> level stays 1, out_dec = 0x10 next cycle.
REQ-042 in_en=0, code 3 -> out_valid=1, out_dec=0x00, out_code=3.
REQ-043 Level=2, then rst_n pulsed low between edges -> out_valid, level and out_dec go 0 without a clock edge, and in_ready=1.

Source files
------------

// File: rtl/decode_nbits_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_nbits_pipe_if
// Description : Handshake bundle for decode_nbits_pipe. Upstream pushes a
//               binary code, downstream pops the stored code and its decode.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_nbits_pipe_if #(
    parameter int N = 3
);
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0]        in_code;
    logic                in_en;
    logic                out_valid;
    logic                out_ready;
    logic [(2**N)-1:0]   out_dec;
    logic [N-1:0]        out_code;
    logic [1:0]          level;

    // Environment side: produces codes and consumes decoded entries
    modport master (
        output in_valid, in_code, in_en, out_ready,
        input  in_ready, out_valid, out_dec, out_code, level
    );

    // Decoder side
    modport slave (
        input  in_valid, in_code, in_en, out_ready,
        output in_ready, out_valid, out_dec, out_code, level
    );
endinterface
`default_nettype wire

// File: rtl/decode_nbits_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decode_nbits_pipe
// Description : N-bit binary to 2**N one-hot / thermometer decoder, decoded at
//               accept time and buffered in a 2-entry FIFO with valid/ready
//               handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_nbits_pipe #(
    parameter int N    = 3,
    parameter int MODE = 0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    decode_nbits_pipe_if.slave bus
);

    localparam int c_dec_w = 2**N;

    logic [c_dec_w-1:0] w_dec;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;

    logic [c_dec_w-1:0] r_mem_dec  [2];
    logic [N-1:0]       r_mem_code [2];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_level;

    // Decode on the input side so the stored word drives the outputs directly
    generate
        for (genvar gi = 0; gi < c_dec_w; gi++) begin : g_dec_bit
            localparam logic [N-1:0] c_idx = N'(gi);
            if (MODE == 0) begin : g_onehot
                assign w_dec[gi] = bus.in_en & (bus.in_code == c_idx);
            end else begin : g_thermo
                assign w_dec[gi] = bus.in_en & (c_idx <= bus.in_code);
            end
        end
    endgenerate

    // Ready depends only on registered occupancy, never on out_ready
    assign w_in_ready  = (r_level != 2'd2);
    assign w_out_valid = (r_level != 2'd0);
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    // Pointer and occupancy bookkeeping; 1-bit pointers wrap modulo 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_level <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 2'd1;
                2'b01:   r_level <= r_level - 2'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Entry storage: decoded word together with the original code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem_dec[i]  <= '0;
                r_mem_code[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_dec[r_wptr]  <= w_dec;
            r_mem_code[r_wptr] <= bus.in_code;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.level     = r_level;
    // Outputs are held at zero whenever the FIFO is empty
    assign bus.out_dec   = w_out_valid ? r_mem_dec[r_rptr]  : '0;
    assign bus.out_code  = w_out_valid ? r_mem_code[r_rptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_decode_nbits_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_nbits_pipe
// Description : Self-checking bench for decode_nbits_pipe (N=3), one instance
//               per decode style, driven with identical stimulus and compared
//               against a queue-based reference model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_nbits_pipe;

    typedef struct packed {
        logic [2:0] code;
        logic       en;
    } entry_t;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    entry_t q[$];

    decode_nbits_pipe_if #(.N(3)) bus0 ();
    decode_nbits_pipe_if #(.N(3)) bus1 ();

    decode_nbits_pipe #(.N(3), .MODE(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    decode_nbits_pipe #(.N(3), .MODE(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected decoded word from the rules: one-hot = 2**code, thermo = 2**(code+1)-1
    function automatic logic [7:0] exp_dec(input int mode, input int code, input bit en);
        int v;
        if (!en) return 8'h00;
        if (mode == 0) v = 1 << code;
        else           v = (2 << code) - 1;
        return v[7:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input int code, input bit en, input bit rdy);
        bus0.in_valid  = v;  bus1.in_valid  = v;
        bus0.in_code   = code[2:0]; bus1.in_code = code[2:0];
        bus0.in_en     = en; bus1.in_en     = en;
        bus0.out_ready = rdy; bus1.out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a bounded queue of accepted codes
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
            end else begin : upd
                bit     push;
                bit     pop;
                entry_t e;
                push = bus0.in_valid && (q.size() < 2);
                pop  = (q.size() > 0) && bus0.out_ready;
                e.code = bus0.in_code;
                e.en   = bus0.in_en;
                if (pop)  void'(q.pop_front());
                if (push) q.push_back(e);
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin : cmp
                int         sz;
                logic [7:0] e0;
                logic [7:0] e1;
                logic [2:0] ec;
                sz = q.size();
                e0 = (sz > 0) ? exp_dec(0, int'(q[0].code), q[0].en) : 8'h00;
                e1 = (sz > 0) ? exp_dec(1, int'(q[0].code), q[0].en) : 8'h00;
                ec = (sz > 0) ? q[0].code : 3'd0;
                chk("m0_level",    64'(bus0.level),     64'(sz));
                chk("m0_in_ready", 64'(bus0.in_ready),  64'(sz < 2));
                chk("m0_out_valid",64'(bus0.out_valid), 64'(sz != 0));
                chk("m0_out_dec",  64'(bus0.out_dec),   64'(e0));
                chk("m0_out_code", 64'(bus0.out_code),  64'(ec));
                chk("m1_level",    64'(bus1.level),     64'(sz));
                chk("m1_out_valid",64'(bus1.out_valid), 64'(sz != 0));
                chk("m1_out_dec",  64'(bus1.out_dec),   64'(e1));
                chk("m1_out_code", 64'(bus1.out_code),  64'(ec));
            end
        end
    end

    logic [7:0] lit_onehot [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] lit_thermo [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

    initial begin
        rst_n = 1'b0;
        drive(1, 5, 1, 1);          // in_valid must be ignored while in reset
        chk_on = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level",     64'(bus0.level),     64'd0);
        chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus0.in_ready),  64'd1);
        chk("rst_out_dec",   64'(bus0.out_dec),   64'h00);
        drive(0, 0, 1, 1);
        #2 rst_n = 1'b1;

        // Back-to-back codes 0..7 with downstream always ready
        for (int k = 0; k < 8; k++) begin
            drive(1, k, 1, 1);
            tick();
            chk("seq_onehot", 64'(bus0.out_dec), 64'(lit_onehot[k]));
            chk("seq_thermo", 64'(bus1.out_dec), 64'(lit_thermo[k]));
            chk("seq_level",  64'(bus0.level),   64'd1);
        end
        drive(0, 0, 1, 1);
        tick();
        chk("drain_valid", 64'(bus0.out_valid), 64'd0);
        chk("drain_dec",   64'(bus0.out_dec),   64'h00);

        // Fill to two entries and try a third push
        drive(1, 5, 1, 0); tick();
        drive(1, 6, 1, 0); tick();
        drive(1, 2, 1, 0); tick();
        chk("full_level",    64'(bus0.level),    64'd2);
        chk("full_in_ready", 64'(bus0.in_ready), 64'd0);
        chk("full_head",     64'(bus0.out_dec),  64'h20);
        drive(1, 2, 1, 1); tick();
        chk("pop1_dec",      64'(bus0.out_dec),  64'h40);
        chk("pop1_level",    64'(bus0.level),    64'd1);
        chk("pop1_in_ready", 64'(bus0.in_ready), 64'd1);
        tick();
        chk("late_accept",   64'(bus0.out_dec),  64'h04);
        chk("late_code",     64'(bus0.out_code), 64'd2);
        drive(0, 0, 1, 0); tick();

        // Simultaneous push and pop at one entry
        drive(1, 4, 1, 1); tick();
        chk("pp_level",  64'(bus0.level),   64'd1);
        chk("pp_dec0",   64'(bus0.out_dec), 64'h10);
        chk("pp_dec1",   64'(bus1.out_dec), 64'h1F);

        // Disabled decode still stores the code
        drive(1, 3, 0, 1); tick();
        chk("en0_valid", 64'(bus0.out_valid), 64'd1);
        chk("en0_dec0",  64'(bus0.out_dec),   64'h00);
        chk("en0_dec1",  64'(bus1.out_dec),   64'h00);
        chk("en0_code",  64'(bus0.out_code),  64'd3);

        // Asynchronous reset while full, observed before any clock edge
        drive(1, 6, 1, 0); tick();
        chk("pre_rst_level", 64'(bus0.level), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid",    64'(bus0.out_valid), 64'd0);
        chk("arst_level",    64'(bus0.level),     64'd0);
        chk("arst_dec",      64'(bus0.out_dec),   64'h00);
        chk("arst_in_ready", 64'(bus0.in_ready),  64'd1);
        tick();
        chk("rst_ignore_push", 64'(bus0.level), 64'd0);
        #2 rst_n = 1'b1;

        // Randomized traffic with occasional mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            bit rdy;
            rdy = ((i / 200) % 3 == 1) ? ($urandom % 4 == 0) : ($urandom % 3 != 0);
            drive($urandom % 4 != 0, int'($urandom % 8), $urandom % 5 != 0, rdy);
            tick();
            if (i % 700 == 350) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        drive(0, 0, 1, 1);
        repeat (3) tick();
        chk_on = 0;
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
